// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and default sizes for the count sequencer.
//   state_e          : controller state (IDLE, RUN, HOLD)
//   DEFAULT_WIDTH    : default counter / limit width in bits
//   DEFAULT_PERIOD_W : default width of the completed-period tally
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PERIOD_W = 8;

endpackage

// File: rtl/count_core.sv
// count_core: synchronous WIDTH-bit up-counter.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, count -> 0
//   clear : load 0 on the next edge (overrides inc)
//   inc   : add 1 (modulo 2^WIDTH) on the next edge
//   count : current counter value (registered)
module count_core #(
  parameter int WIDTH = count_seq_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: sequences a WIDTH-bit up-counter through programmable runs.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : begin a run (taken only while idle)
//   limit       : terminal count, latched on an accepted start
//   auto_reload : latched on an accepted start; restart at 0 after terminal
//   hold        : freeze the count while running
//   abort       : cancel the current run, count -> 0
//   count       : current counter value
//   busy        : high while a run is active (RUN or HOLD)
//   done        : one-cycle pulse per completed run
//   periods     : completed runs since the last accepted start (saturating)
//   dbg_state   : current controller state, for observation only
//
// Handshake: start is a command with no ready input of its own. It is
// accepted on a rising edge only when busy is low; while busy is high the
// block is not ready and start is dropped without effect. All outputs are
// registered.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    limit,
  input  logic                auto_reload,
  input  logic                hold,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic [PERIOD_W-1:0] periods,
  output state_e              dbg_state
);

  state_e              state_d, state_q;
  logic [WIDTH-1:0]    limit_d, limit_q;
  logic                reload_d, reload_q;
  logic [PERIOD_W-1:0] periods_d, periods_q;
  logic                done_d, done_q;
  logic                busy_d, busy_q;
  logic                core_clear;
  logic                core_inc;
  logic [WIDTH-1:0]    count_w;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clear (core_clear),
    .inc   (core_inc),
    .count (count_w)
  );

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    reload_d   = reload_q;
    periods_d  = periods_q;
    done_d     = 1'b0;
    core_clear = 1'b0;
    core_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_clear = 1'b1;
          limit_d    = limit;
          reload_d   = auto_reload;
          if (limit != '0) begin
            state_d   = ST_RUN;
            periods_d = '0;
          end else begin
            // Zero-length run: completes immediately without leaving IDLE.
            done_d    = 1'b1;
            periods_d = PERIOD_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          core_clear = 1'b1;
          state_d    = ST_IDLE;
        end else if (hold) begin
          // Hold wins over terminal detection; count stays frozen.
          state_d = ST_HOLD;
        end else if (count_w == limit_q) begin
          done_d = 1'b1;
          if (periods_q != '1) begin
            periods_d = periods_q + PERIOD_W'(1);
          end
          if (reload_q) begin
            core_clear = 1'b1;
          end else begin
            // Count is left parked at the terminal value.
            state_d = ST_IDLE;
          end
        end else begin
          core_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          core_clear = 1'b1;
          state_d    = ST_IDLE;
        end else if (!hold) begin
          // Leaving HOLD costs one edge with no increment.
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      reload_q  <= 1'b0;
      periods_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      reload_q  <= reload_d;
      periods_q <= periods_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign count     = count_w;
  assign busy      = busy_q;
  assign done      = done_q;
  assign periods   = periods_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: two instances (PERIOD_W=8 and PERIOD_W=2) share one
// stimulus stream; a behavioural model predicts every output each cycle.
module tb_count_sequencer;

  localparam int W     = 4;
  localparam int MAXC  = 1 << W;
  localparam int PW_A  = 8;
  localparam int PW_B  = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  limit;
  logic          auto_reload;
  logic          hold;
  logic          abort;

  logic [W-1:0]    count_a, count_b;
  logic            busy_a, busy_b;
  logic            done_a, done_b;
  logic [PW_A-1:0] periods_a;
  logic [PW_B-1:0] periods_b;
  count_seq_pkg::state_e dbg_a, dbg_b;

  count_sequencer #(.WIDTH(W), .PERIOD_W(PW_A)) dut_a (
    .clk(clk), .reset(reset), .start(start), .limit(limit),
    .auto_reload(auto_reload), .hold(hold), .abort(abort),
    .count(count_a), .busy(busy_a), .done(done_a), .periods(periods_a),
    .dbg_state(dbg_a)
  );

  count_sequencer #(.WIDTH(W), .PERIOD_W(PW_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .limit(limit),
    .auto_reload(auto_reload), .hold(hold), .abort(abort),
    .count(count_b), .busy(busy_b), .done(done_b), .periods(periods_b),
    .dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the run as plain integers: whether a run is active, whether it is
  // frozen, the current value, and an unbounded tally of completed runs.
  bit m_valid  = 0;
  bit m_active = 0;
  bit m_frozen = 0;
  bit m_rel    = 0;
  bit m_done   = 0;
  int m_count  = 0;
  int m_lim    = 0;
  int m_tally  = 0;

  function automatic int sat(input int v, input int bits);
    int top;
    top = (1 << bits) - 1;
    return (v > top) ? top : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_frozen = 0; m_done = 0;
      m_count = 0; m_tally = 0; m_lim = 0; m_rel = 0;
      m_valid = 1;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin
          m_lim   = int'(limit);
          m_rel   = auto_reload;
          m_count = 0;
          if (limit != 0) begin
            m_active = 1; m_frozen = 0; m_tally = 0;
          end else begin
            m_done = 1; m_tally = 1;
          end
        end
      end else if (abort) begin
        m_active = 0; m_frozen = 0; m_count = 0;
      end else if (hold) begin
        m_frozen = 1;
      end else if (m_frozen) begin
        m_frozen = 0;
      end else if (m_count == m_lim) begin
        m_done  = 1;
        m_tally = m_tally + 1;
        if (m_rel) m_count = 0;
        else       m_active = 0;
      end else begin
        m_count = (m_count + 1) % MAXC;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count_a",   int'(count_a),   m_count);
      chk("busy_a",    int'(busy_a),    int'(m_active));
      chk("done_a",    int'(done_a),    int'(m_done));
      chk("periods_a", int'(periods_a), sat(m_tally, PW_A));
      chk("count_b",   int'(count_b),   m_count);
      chk("periods_b", int'(periods_b), sat(m_tally, PW_B));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int lim, input bit rel);
    start = 1'b1; limit = W'(lim); auto_reload = rel;
    cyc();
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq2 [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int n;

    reset = 1'b1; start = 1'b0; limit = '0; auto_reload = 1'b0;
    hold = 1'b0; abort = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_count", int'(count_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_periods", int'(periods_a), 0);

    // limit=3, no reload: 0,1,2,3 then done on the 5th edge with busy falling
    do_start(3, 0);
    chk("t1_count0", int'(count_a), 0);
    chk("t1_busy0", int'(busy_a), 1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("t1_countk", int'(count_a), k);
    end
    cyc();
    chk("t1_done", int'(done_a), 1);
    chk("t1_busy_fall", int'(busy_a), 0);
    chk("t1_count_park", int'(count_a), 3);
    chk("t1_periods", int'(periods_a), 1);
    cyc();
    chk("t1_done_once", int'(done_a), 0);
    chk("t1_count_hold", int'(count_a), 3);

    // limit=2 with reload
    do_start(2, 1);
    for (int k = 0; k < 9; k++) begin
      chk("t2_seq", int'(count_a), seq2[k]);
      chk("t2_done", int'(done_a), (k == 3 || k == 6) ? 1 : 0);
      cyc();
    end
    chk("t2_done3", int'(done_a), 1);
    chk("t2_periods", int'(periods_a), 3);
    chk("t2_busy", int'(busy_a), 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t2_abort_busy", int'(busy_a), 0);
    chk("t2_abort_count", int'(count_a), 0);

    // limit=5 with a 2-cycle hold at count=2
    do_start(5, 0);
    cyc(); cyc();
    chk("t3_count2", int'(count_a), 2);
    hold = 1'b1;
    cyc(); chk("t3_hold_a", int'(count_a), 2);
    cyc(); chk("t3_hold_b", int'(count_a), 2);
    hold = 1'b0;
    cyc(); chk("t3_hold_c", int'(count_a), 2);
    n = 5;
    while (done_a !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("t3_done_latency", n, 9);

    // limit=9, start retried mid-run, abort at count=4
    do_start(9, 0);
    cyc(); cyc();
    start = 1'b1; limit = W'(2); auto_reload = 1'b1;
    cyc(); chk("t4_ignore_start3", int'(count_a), 3);
    cyc(); chk("t4_ignore_start4", int'(count_a), 4);
    start = 1'b0; abort = 1'b1;
    cyc(); abort = 1'b0;
    chk("t4_abort_count", int'(count_a), 0);
    chk("t4_abort_busy", int'(busy_a), 0);
    chk("t4_abort_done", int'(done_a), 0);
    cyc();
    chk("t4_idle_busy", int'(busy_a), 0);
    chk("t4_idle_done", int'(done_a), 0);

    // zero-length run
    do_start(0, 0);
    chk("t5_done", int'(done_a), 1);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_periods", int'(periods_a), 1);
    cyc();
    chk("t5_done_once", int'(done_a), 0);
    chk("t5_busy_low", int'(busy_a), 0);

    // limit=15 reload, 5 periods: PERIOD_W=2 instance saturates at 3
    do_start(15, 1);
    repeat (80) cyc();
    chk("t6_done", int'(done_a), 1);
    chk("t6_periods_a", int'(periods_a), 5);
    chk("t6_periods_b", int'(periods_b), 3);
    repeat (3) cyc();
    chk("t6_count3", int'(count_a), 3);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t6_rst_count", int'(count_a), 0);
    chk("t6_rst_busy", int'(busy_a), 0);
    chk("t6_rst_periods", int'(periods_b), 0);
    chk("t6_rst_done", int'(done_a), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       limit = '0;
        1:       limit = '1;
        default: limit = W'($urandom_range(0, MAXC - 1));
      endcase
      auto_reload = 1'($urandom_range(0, 1));
      hold        = ($urandom_range(0, 4) == 0);
      abort       = ($urandom_range(0, 24) == 0);
      cyc();
    end
    reset = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
